// File: rtl/sdp_rd_addr_gen_pkg.sv
// Shared definitions for the SDP read address generator.
//   - Command field layout: data = {count[W_LEN-1:0], base[W_ADDR-1:0]}
//   - Generator state encoding (IDLE = output empty, BURST = output valid)
package sdp_rd_addr_gen_pkg;

    // The base address sits in the low bits of the command word and the
    // burst count sits directly above it.
    localparam int CMD_BASE_LSB = 0;

    function automatic int cmd_len_lsb(input int w_addr);
        return CMD_BASE_LSB + w_addr;
    endfunction

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/sdp_rd_addr_gen_if.sv
// dti valid/ready stream with an end-of-transfer marker.
//   valid : producer -> consumer, data/eot qualified by valid
//   ready : consumer -> producer, transfer when valid & ready
//   data  : W-bit payload
//   eot   : last beat of a transfer
// producer/consumer and master/slave are equivalent views.
interface dti #(
    parameter int W = 16
) ();
    logic         valid;
    logic         ready;
    logic         eot;
    logic [W-1:0] data;

    modport producer (output valid, data, eot, input ready);
    modport consumer (input valid, data, eot, output ready);
    modport master   (output valid, data, eot, input ready);
    modport slave    (input valid, data, eot, output ready);
endinterface

// File: rtl/sdp_rd_addr_gen.sv
// Burst address generator feeding the SDP memory read port.
// Each accepted command {count, base} expands into `count` addresses
// base, base+STRIDE, ... (mod 2^W_ADDR) with eot on the last one.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active low
//   cmd_if  : command consumer, data = {count, base}, eot unused
//   addr_if : address producer, eot on the final beat of each burst
// All addr_if outputs are flops; cmd_if.ready depends only on state and
// addr_if.ready, so the command source never sees a path through here
// from its own valid.
module sdp_rd_addr_gen
    import sdp_rd_addr_gen_pkg::*;
#(
    parameter int W_ADDR = 16,
    parameter int W_LEN  = 8,
    parameter int STRIDE = 1
) (
    input logic   clk,
    input logic   rst,
    dti.consumer  cmd_if,
    dti.producer  addr_if
);

    localparam int LEN_LSB = cmd_len_lsb(W_ADDR);

    state_t              state_q;
    logic [W_ADDR-1:0]   addr_q;
    logic [W_LEN-1:0]    rem_q;   // beats left after the one on the output
    logic                eot_q;

    logic [W_ADDR-1:0]   cmd_base;
    logic [W_LEN-1:0]    cmd_len;
    logic                valid_q;
    logic                out_hs;
    logic                cmd_rdy;
    logic                cmd_acc;

    assign cmd_base = cmd_if.data[CMD_BASE_LSB +: W_ADDR];
    assign cmd_len  = cmd_if.data[LEN_LSB +: W_LEN];

    assign valid_q  = (state_q == S_BURST);
    assign out_hs   = valid_q & addr_if.ready;
    // Take a new command when empty, or when the last beat leaves this
    // cycle so consecutive bursts run without a bubble.
    assign cmd_rdy  = !valid_q | (addr_if.ready & eot_q);
    assign cmd_acc  = cmd_if.valid & cmd_rdy;

    assign cmd_if.ready  = cmd_rdy;
    assign addr_if.valid = valid_q;
    assign addr_if.data  = addr_q;
    assign addr_if.eot   = eot_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            eot_q   <= 1'b0;
        end else if (cmd_acc && (cmd_len != '0)) begin
            state_q <= S_BURST;
            addr_q  <= cmd_base;
            rem_q   <= cmd_len - W_LEN'(1);
            eot_q   <= (cmd_len == W_LEN'(1));
        end else if (out_hs) begin
            // A zero-count command accepted alongside the last beat lands
            // here too: it emits nothing and the output simply empties.
            if (eot_q) begin
                state_q <= S_IDLE;
                eot_q   <= 1'b0;
            end else begin
                addr_q  <= addr_q + W_ADDR'(STRIDE);
                rem_q   <= rem_q - W_LEN'(1);
                eot_q   <= (rem_q == W_LEN'(1));
            end
        end
    end

endmodule

// File: tb/tb_sdp_rd_addr_gen.sv
// Scoreboard bench for sdp_rd_addr_gen. Two instances: STRIDE=1 (a) and
// STRIDE=4 (b). Stimulus pushes hand-computed beats into per-DUT queues;
// a negedge monitor pops and compares on every output handshake.
module tb_sdp_rd_addr_gen;

    typedef struct {
        logic [15:0] addr;
        logic        eot;
    } exp_t;

    logic clk;
    logic rst;

    dti #(.W(24)) cmd_a ();
    dti #(.W(16)) addr_a ();
    dti #(.W(24)) cmd_b ();
    dti #(.W(16)) addr_b ();

    sdp_rd_addr_gen #(.W_ADDR(16), .W_LEN(8), .STRIDE(1)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .cmd_if  (cmd_a),
        .addr_if (addr_a)
    );

    sdp_rd_addr_gen #(.W_ADDR(16), .W_LEN(8), .STRIDE(4)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .cmd_if  (cmd_b),
        .addr_if (addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_pop_a = 0;
    int   pop_cyc[256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int w, input logic v, input logic r, input logic crdy,
                       input logic [15:0] d, input logic e);
        exp_t ex;
        int   sz;
        sz = (w == 0) ? q_a.size() : q_b.size();
        if (!v) return;
        if (sz == 0) begin
            if (r) chk(w == 0 ? "a_unexpected_beat" : "b_unexpected_beat", {15'd0, d, e}, 32'd0);
            return;
        end
        ex = (w == 0) ? q_a[0] : q_b[0];
        if (r) begin
            if (w == 0) begin
                void'(q_a.pop_front());
                if (n_pop_a < 256) pop_cyc[n_pop_a] = cyc;
                n_pop_a++;
            end else begin
                void'(q_b.pop_front());
            end
            chk(w == 0 ? "a_addr" : "b_addr", {16'd0, d}, {16'd0, ex.addr});
            chk(w == 0 ? "a_eot" : "b_eot", {31'd0, e}, {31'd0, ex.eot});
            // With the output draining, a command is takeable only on the last beat.
            chk(w == 0 ? "a_cmd_ready_beat" : "b_cmd_ready_beat", {31'd0, crdy}, {31'd0, ex.eot});
        end else begin
            chk(w == 0 ? "a_hold_addr" : "b_hold_addr", {16'd0, d}, {16'd0, ex.addr});
            chk(w == 0 ? "a_hold_eot" : "b_hold_eot", {31'd0, e}, {31'd0, ex.eot});
            chk(w == 0 ? "a_cmd_ready_stall" : "b_cmd_ready_stall", {31'd0, crdy}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon(0, addr_a.valid, addr_a.ready, cmd_a.ready, addr_a.data, addr_a.eot);
            mon(1, addr_b.valid, addr_b.ready, cmd_b.ready, addr_b.data, addr_b.eot);
        end
    end

    task automatic push(input int w, input logic [15:0] a, input logic e);
        exp_t x;
        x.addr = a;
        x.eot  = e;
        if (w == 0) q_a.push_back(x);
        else        q_b.push_back(x);
    endtask

    // Called at posedge+1; returns at the next posedge+1 after acceptance.
    task automatic send_cmd(input int w, input logic [7:0] cnt, input logic [15:0] base,
                            output int waits);
        logic rdy;
        waits = 0;
        if (w == 0) begin cmd_a.data = {cnt, base}; cmd_a.valid = 1'b1; end
        else        begin cmd_b.data = {cnt, base}; cmd_b.valid = 1'b1; end
        forever begin
            @(negedge clk);
            rdy = (w == 0) ? cmd_a.ready : cmd_b.ready;
            if (rdy || waits > 100) break;
            waits++;
        end
        if (!rdy) chk("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (w == 0) cmd_a.valid = 1'b0;
        else        cmd_b.valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", q_a.size() + q_b.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int n0;
        int n;

        rst = 1'b0;
        cmd_a.valid = 1'b0; cmd_a.data = '0; cmd_a.eot = 1'b0;
        cmd_b.valid = 1'b0; cmd_b.data = '0; cmd_b.eot = 1'b0;
        addr_a.ready = 1'b1;
        addr_b.ready = 1'b1;

        #1;
        chk("rst_valid", {31'd0, addr_a.valid}, 32'd0);
        chk("rst_eot",   {31'd0, addr_a.eot},   32'd0);
        chk("rst_data",  {16'd0, addr_a.data},  32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_a.ready}, 32'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: single burst of 4
        push(0, 16'h0010, 1'b0); push(0, 16'h0011, 1'b0);
        push(0, 16'h0012, 1'b0); push(0, 16'h0013, 1'b1);
        send_cmd(0, 8'd4, 16'h0010, w);
        wait_drain();

        // 2: back-to-back bursts, no bubble
        n0 = n_pop_a;
        push(0, 16'h0100, 1'b0); push(0, 16'h0101, 1'b0); push(0, 16'h0102, 1'b1);
        push(0, 16'h0200, 1'b0); push(0, 16'h0201, 1'b1);
        send_cmd(0, 8'd3, 16'h0100, w);
        send_cmd(0, 8'd2, 16'h0200, w);
        wait_drain();
        chk("b2b_no_bubble", pop_cyc[n0 + 4] - pop_cyc[n0], 32'd4);

        // 3: stride 4 with wrap
        push(1, 16'hFFF8, 1'b0); push(1, 16'hFFFC, 1'b0); push(1, 16'h0000, 1'b1);
        send_cmd(1, 8'd3, 16'hFFF8, w);
        wait_drain();

        // 4: backpressure 1,0,0,1,1
        push(0, 16'h0040, 1'b0); push(0, 16'h0041, 1'b0); push(0, 16'h0042, 1'b1);
        send_cmd(0, 8'd3, 16'h0040, w);
        addr_a.ready = 1'b1; @(posedge clk); #1;
        addr_a.ready = 1'b0; @(posedge clk); #1;
        addr_a.ready = 1'b0; @(posedge clk); #1;
        addr_a.ready = 1'b1; @(posedge clk); #1;
        addr_a.ready = 1'b1;
        wait_drain();

        // 5: zero-count command between two single-beat bursts
        push(0, 16'h0008, 1'b1); push(0, 16'h0009, 1'b1);
        send_cmd(0, 8'd1, 16'h0008, w);
        send_cmd(0, 8'd0, 16'hABCD, w);
        chk("zero_cmd_one_cycle", w, 32'd0);
        send_cmd(0, 8'd1, 16'h0009, w);
        wait_drain();

        // 6: async reset mid-burst after two beats
        n0 = n_pop_a;
        for (int i = 0; i < 8; i++) push(0, 16'(i), (i == 7));
        send_cmd(0, 8'd8, 16'h0000, w);
        n = 0;
        while (n_pop_a < n0 + 2 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("mid_burst_beats", n_pop_a - n0, 32'd2);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, addr_a.valid}, 32'd0);
        chk("async_rst_eot",   {31'd0, addr_a.eot},   32'd0);
        chk("async_rst_cmd_ready", {31'd0, cmd_a.ready}, 32'd1);
        q_a.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, addr_a.valid}, 32'd0);
        chk("post_rst_cmd_ready", {31'd0, cmd_a.ready}, 32'd1);

        chk("final_queue_a", q_a.size(), 32'd0);
        chk("final_queue_b", q_b.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
